// File: rtl/circuit_pkg.sv
// Shared constants for the circuit function cell and its decoder.
package circuit_pkg;

    // Default truth table: minterms 1,3,4,11,12,13,14,15 (bit index = {a,b,c,d}).
    localparam logic [15:0] DEFAULT_TT = 16'hF81A;

    // Mux select width ({a,b}) and decoder output width (one line per {c,d} value).
    localparam int SEL_W = 2;
    localparam int DEC_W = 4;

endpackage : circuit_pkg

// File: rtl/circuit_dec2to4.sv
// 2-to-4 one-hot decoder: y[k] is high exactly when {c,d} == k.
module dec2to4
    import circuit_pkg::*;
(
    input  logic             c,
    input  logic             d,
    output logic [DEC_W-1:0] y
);

    // Decode {c,d} into a single active minterm line.
    always_comb begin
        // NOTE: assign a default before the selective write so every path drives y and no latch is inferred.
        y         = '0;
        y[{c, d}] = 1'b1;
    end

endmodule : dec2to4

// File: rtl/circuit.sv
// circuit: registered 4-input Boolean function F(a,b,c,d).
// A 2x4 decoder on {c,d} feeds OR terms built from TRUTH_TABLE; {a,b} select
// one of the four terms through a 4x1 mux, and the result is registered.
// Optional macro INPUT_REG_EN adds an input register stage (latency 2).
module circuit
    import circuit_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TT
)(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic F
);

    // Function inputs as seen by the decoder and mux.
    logic a_s;
    logic b_s;
    logic c_s;
    logic d_s;

`ifdef INPUT_REG_EN
    // Input stage: capture a..d, cleared to zero by reset so the output
    // settles to TRUTH_TABLE[0] until real data arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is written with non-blocking assignments so all registers update together.
            a_s <= 1'b0;
            b_s <= 1'b0;
            c_s <= 1'b0;
            d_s <= 1'b0;
        end else begin
            a_s <= a;
            b_s <= b;
            c_s <= c;
            d_s <= d;
        end
    end
`else
    // Without the input stage the decoder and mux see the ports directly.
    always_comb begin
        a_s = a;
        b_s = b;
        c_s = c;
        d_s = d;
    end
`endif

    logic [DEC_W-1:0] y;
    logic [DEC_W-1:0] mux_in;
    logic [SEL_W-1:0] sel;
    logic             m;

    dec2to4 u_dec (
        .c (c_s),
        .d (d_s),
        .y (y)
    );

    // Mux data inputs: each is the OR of the minterm lines enabled in its
    // nibble of the truth table, then {a,b} picks one of them.
    always_comb begin
        mux_in = '0;
        for (int s = 0; s < DEC_W; s++) begin
            mux_in[s] = |(y & TRUTH_TABLE[DEC_W*s +: DEC_W]);
        end
        sel = {a_s, b_s};
        m   = mux_in[sel];
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            F <= 1'b0;
        end else begin
            F <= m;
        end
    end

endmodule : circuit

// File: tb/tb_circuit.sv
// Self-checking bench for circuit: three instances (default, 16'h0001,
// 16'hFFFF truth tables) share random stimulus; a model pushes expected
// outputs into a queue and a monitor pops and compares each cycle.
// Define INPUT_REG_EN to build the bench for the 2-cycle variant.
module tb_circuit;

    localparam logic [15:0] TT_DEF = 16'hF81A;
    localparam logic [15:0] TT_ONE = 16'h0001;
    localparam logic [15:0] TT_FF  = 16'hFFFF;

    typedef struct packed {
        logic f_def;
        logic f_one;
        logic f_ff;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] abcd = 4'b1111;
    logic f_def, f_one, f_ff;

    logic       dc = 1'b0, dd = 1'b0;
    logic [3:0] dy;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    bit model_on = 1'b1;

    always #5 clk = ~clk;

    circuit u_def (.clk(clk), .rst(rst), .a(abcd[3]), .b(abcd[2]), .c(abcd[1]), .d(abcd[0]), .F(f_def));
    circuit #(.TRUTH_TABLE(16'h0001)) u_one (.clk(clk), .rst(rst), .a(abcd[3]), .b(abcd[2]), .c(abcd[1]), .d(abcd[0]), .F(f_one));
    circuit #(.TRUTH_TABLE(16'hFFFF)) u_ff (.clk(clk), .rst(rst), .a(abcd[3]), .b(abcd[2]), .c(abcd[1]), .d(abcd[0]), .F(f_ff));
    dec2to4 u_dec (.c(dc), .d(dd), .y(dy));

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference: F is a truth-table lookup of the inputs seen `latency`
    // edges ago, forced to 0 on reset edges; with the input stage a reset
    // also leaves the stored inputs at 0.
    logic [3:0] stage = 4'b0000;
    always @(posedge clk) begin
        logic [3:0] idx;
        exp_t e;
`ifdef INPUT_REG_EN
        idx   = stage;
        stage = rst ? 4'b0000 : abcd;
`else
        idx = abcd;
`endif
        e.f_def = rst ? 1'b0 : TT_DEF[idx];
        e.f_one = rst ? 1'b0 : TT_ONE[idx];
        e.f_ff  = rst ? 1'b0 : TT_FF[idx];
        if (model_on) exp_q.push_back(e);
    end

    // Monitor: the output is valid every cycle; compare just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("F_default", {3'b0, f_def}, {3'b0, e.f_def});
            check("F_tt0001",  {3'b0, f_one}, {3'b0, e.f_one});
            check("F_ttFFFF",  {3'b0, f_ff},  {3'b0, e.f_ff});
        end
    end

    task automatic drive(input logic r, input logic [3:0] v);
        @(negedge clk);
        rst  = r;
        abcd = v;
    endtask

    initial begin
        // Decoder unit check: one-hot for every {c,d}.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want;
            want = 4'b0001 << k;
            {dc, dd} = k[1:0];
            #1;
            check("dec_y", dy, want);
            check("dec_onehot", {3'b0, $onehot(dy)}, 4'b0001);
        end

        // Reset held two cycles with all inputs high, then release.
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);
        drive(1'b0, 4'b1111);
        drive(1'b0, 4'b1111);

        // Exhaustive sweep.
        for (int i = 0; i < 16; i++) drive(1'b0, 4'(i));

        // Mid-stream reset while holding 1100.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1100);
        drive(1'b1, 4'b1100);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b1100);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
        end

        // Drain the pipeline and stop the model.
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        @(negedge clk);
        model_on = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_circuit

// File: doc/circuit.md
Name: circuit

Overview:
- Evaluates a 4-input Boolean function F(a,b,c,d), implemented as a 2x4 decoder feeding a 4x1 multiplexer.
- Decoder decodes {c,d} into one-hot minterm lines; per-mux-input OR terms over those lines form the four data inputs; {a,b} drive the mux select.
- Mux output is registered on clk; F is a registered, synchronously reset output.
- Leaf block used as a small combinational-function cell in larger control logic.

Parameters:
- TRUTH_TABLE, 16'hF81A, function truth table. Bit index = {a,b,c,d}, a is MSB. Default = minterms 1,3,4,11,12,13,14,15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  1  function input, mux select MSB
- b  input  1  function input, mux select LSB
- c  input  1  function input, decoder input MSB
- d  input  1  function input, decoder input LSB
- F  output  1  registered function result

Behaviour:
- One clock domain (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Decoder: y[k] = 1 iff {c,d} == k, for k = 0..3. Exactly one line is high.
- Mux data input I[s] = OR over k of (y[k] AND TRUTH_TABLE[4*s+k]), for s = 0..3.
- Mux output m = I[{a,b}].
- Default mux data inputs:
  - I0 = d (m1|m3)
  - I1 = ~c&~d (m0)
  - I2 = c&d (m3)
  - I3 = 1
- F register:
  - On a clk edge with rst=1: F <= 0.
  - Otherwise: F <= m.
- Latency: 1 cycle from input change to F.
- No enable. Inputs are sampled every cycle.
- rst mid-operation: F is 0 on the following cycle. The next valid result appears one cycle after rst deasserts.
- If rst and an input change occur in the same cycle, reset wins.
- Inputs are assumed synchronous to clk. No X-propagation handling is required.

Optional Feature:
- Macro INPUT_REG_EN.
- Defined:
  - a,b,c,d are registered before the decoder/mux.
  - Latency is 2 cycles.
  - rst clears the input registers and F to 0. While held in reset, F outputs 0.
  - After rst deasserts, F = TRUTH_TABLE[0] until real input data reaches the output stage.
- Undefined: single output register, latency 1.

Decomposition:
- Shared package circuit_pkg:
  - DEFAULT_TT = 16'hF81A
  - SEL_W = 2
  - DEC_W = 4
- Sub-module dec2to4: inputs c,d; output one-hot y[3:0]; purely combinational.
- The 4x1 mux and the OR terms stay inline in circuit.

Test Plan:
- Reset: rst=1 for 2 cycles with inputs a,b,c,d = 1,1,1,1 -> F=0 throughout. Release rst -> F=1 one cycle later.
- Exhaustive sweep of {a,b,c,d} = 0..15, one value per cycle -> F follows 0,1,0,1, 1,0,0,0, 0,0,0,1, 1,1,1,1, delayed by 1 cycle (2 cycles with INPUT_REG_EN).
- Mid-stream reset: hold {a,b,c,d}=4'b1100 (F=1), assert rst for 1 cycle -> F=0 for that cycle, then F=1 again.
- Parameter override: TRUTH_TABLE=16'h0001, sweep 0..15 -> F=1 only for input 0.
- Parameter override: TRUTH_TABLE=16'hFFFF, sweep 0..15 -> F=1 for all inputs.
- Decoder unit check: sweep {c,d} = 0..3 -> y = 0001, 0010, 0100, 1000 (one-hot, never zero, never multi-hot).
